// File: rtl/reg_file_if.sv
// Register-file bus: write ports, read ports, debug read and commit counter.
// master drives IDs and write data; slave (the register file) returns read data.
interface reg_file_if #(
    parameter int DATA_W = 64
);
    logic              wr_en;
    logic [3:0]        dstE;
    logic [DATA_W-1:0] valE;
    logic [3:0]        dstM;
    logic [DATA_W-1:0] valM;
    logic [3:0]        srcA;
    logic [3:0]        srcB;
    logic [DATA_W-1:0] valA;
    logic [DATA_W-1:0] valB;
    logic [3:0]        dbg_sel;
    logic [DATA_W-1:0] dbg_val;
    logic [15:0]       wr_count;

    modport master (
        output wr_en, dstE, valE, dstM, valM, srcA, srcB, dbg_sel,
        input  valA, valB, dbg_val, wr_count
    );

    modport slave (
        input  wr_en, dstE, valE, dstM, valM, srcA, srcB, dbg_sel,
        output valA, valB, dbg_val, wr_count
    );
endinterface

// File: rtl/reg_file.sv
// Y86-64 register file: 15 x DATA_W registers, E/M write ports, A/B read ports,
// debug read, optional same-cycle forwarding and a saturating commit counter.
module reg_file #(
    parameter int                 DATA_W     = 64,
    parameter logic [DATA_W-1:0]  STACK_INIT = '0,
    parameter int                 BYPASS     = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    reg_file_if.slave  bus
);
    localparam logic [3:0] RNONE = 4'hF;

    logic [DATA_W-1:0] regs [0:14];
    logic [DATA_W-1:0] view [0:15];
    logic [15:0]       count;
    logic              e_wr;
    logic              m_wr;
    logic              e_eff;
    logic [1:0]        n_wr;
    logic              fwd_en;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {15'd0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    assign e_wr   = (bus.dstE != RNONE);
    assign m_wr   = (bus.dstM != RNONE);
    // A shared destination is one register written, so E drops out of the count.
    assign e_eff  = e_wr && !(m_wr && (bus.dstE == bus.dstM));
    assign n_wr   = {1'b0, e_eff} + {1'b0, m_wr};
    assign fwd_en = (BYPASS != 0) && rst_n && bus.wr_en;

    always_comb begin
        for (int i = 0; i < 15; i++) view[i] = regs[i];
        view[15] = '0;
    end

    always_comb begin
        bus.valA = view[bus.srcA];
        bus.valB = view[bus.srcB];
        if (fwd_en && bus.srcA != RNONE) begin
            if (bus.srcA == bus.dstM)      bus.valA = bus.valM;
            else if (bus.srcA == bus.dstE) bus.valA = bus.valE;
        end
        if (fwd_en && bus.srcB != RNONE) begin
            if (bus.srcB == bus.dstM)      bus.valB = bus.valM;
            else if (bus.srcB == bus.dstE) bus.valB = bus.valE;
        end
    end

    assign bus.dbg_val  = view[bus.dbg_sel];
    assign bus.wr_count = count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) regs[i] <= (i == 4) ? STACK_INIT : '0;
            count <= '0;
        end else if (bus.wr_en) begin
            // M is checked first so popq %rsp keeps the popped value.
            for (int i = 0; i < 15; i++) begin
                if (m_wr && bus.dstM == 4'(i))      regs[i] <= bus.valM;
                else if (e_wr && bus.dstE == 4'(i)) regs[i] <= bus.valE;
            end
            count <= sat_add(count, n_wr);
        end
    end
endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: one BYPASS=0 and one BYPASS=1 instance share
// the same stimulus; expectations are queued and checked at each falling edge.
module tb_reg_file;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    reg_file_if #(.DATA_W(64)) bus0 ();
    reg_file_if #(.DATA_W(64)) bus1 ();

    assign bus1.wr_en   = bus0.wr_en;
    assign bus1.dstE    = bus0.dstE;
    assign bus1.valE    = bus0.valE;
    assign bus1.dstM    = bus0.dstM;
    assign bus1.valM    = bus0.valM;
    assign bus1.srcA    = bus0.srcA;
    assign bus1.srcB    = bus0.srcB;
    assign bus1.dbg_sel = bus0.dbg_sel;

    reg_file #(.DATA_W(64), .STACK_INIT(64'h200), .BYPASS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    reg_file #(.DATA_W(64), .STACK_INIT(64'h200), .BYPASS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    typedef struct {
        int          sig;
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // sig: 0 valA0, 1 valB0, 2 dbg0, 3 cnt0, 4 valA1, 5 valB1, 6 dbg1, 7 cnt1
    function automatic void push(input int sig, input logic [63:0] e, input string n);
        exp_t it;
        it.sig = sig; it.exp = e; it.name = n;
        sb.push_back(it);
    endfunction

    function automatic void push_reads(input logic [63:0] a, input logic [63:0] b,
                                       input logic [63:0] d, input string n);
        push(0, a, {n, "_valA0"}); push(1, b, {n, "_valB0"}); push(2, d, {n, "_dbg0"});
        push(4, a, {n, "_valA1"}); push(5, b, {n, "_valB1"}); push(6, d, {n, "_dbg1"});
    endfunction

    function automatic void push_cnt(input logic [15:0] c, input string n);
        push(3, {48'd0, c}, {n, "_cnt0"});
        push(7, {48'd0, c}, {n, "_cnt1"});
    endfunction

    always @(negedge clk) begin
        exp_t        it;
        logic [63:0] act;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            case (it.sig)
                0: act = bus0.valA;
                1: act = bus0.valB;
                2: act = bus0.dbg_val;
                3: act = {48'd0, bus0.wr_count};
                4: act = bus1.valA;
                5: act = bus1.valB;
                6: act = bus1.dbg_val;
                default: act = {48'd0, bus1.wr_count};
            endcase
            tests++;
            if (act !== it.exp) begin
                fails++;
                $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm);
        bus0.wr_en = we; bus0.dstE = de; bus0.valE = ve; bus0.dstM = dm; bus0.valM = vm;
    endtask

    task automatic rd(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
        bus0.srcA = a; bus0.srcB = b; bus0.dbg_sel = d;
    endtask

    initial begin
        // Reset edge with a pending write to reg3 that must be discarded.
        rst_n = 1'b0;
        drive(1'b1, 4'd3, 64'h5, 4'hF, 64'h0);
        rd(4'hF, 4'hF, 4'hF);
        step();
        rst_n = 1'b1;
        drive(1'b0, 4'hF, 64'h0, 4'hF, 64'h0);
        for (int id = 0; id < 16; id++) begin
            rd(4'(id), 4'(id), 4'(id));
            push_reads((id == 4) ? 64'h200 : 64'h0, (id == 4) ? 64'h200 : 64'h0,
                       (id == 4) ? 64'h200 : 64'h0, $sformatf("reset_r%0d", id));
            if (id == 0) push_cnt(16'd0, "reset");
            step();
        end

        // Dual write; BYPASS=1 forwards valE during the write cycle.
        drive(1'b1, 4'd2, 64'hAA, 4'd7, 64'hBB);
        rd(4'd2, 4'd7, 4'd2);
        push(0, 64'h0, "dual_pre_valA0"); push(4, 64'hAA, "dual_fwd_valA1");
        push(1, 64'h0, "dual_pre_valB0"); push(5, 64'hBB, "dual_fwd_valB1");
        push(6, 64'h0, "dual_pre_dbg1");
        step();
        drive(1'b0, 4'hF, 64'h0, 4'hF, 64'h0);
        push_reads(64'hAA, 64'hBB, 64'hAA, "dual");
        push_cnt(16'd2, "dual");
        step();

        // Conflict on %rsp: M wins both in storage and in forwarding.
        drive(1'b1, 4'd4, 64'h1F0, 4'd4, 64'h55);
        rd(4'd4, 4'd4, 4'd4);
        push(0, 64'h200, "conf_pre_valA0"); push(4, 64'h55, "conf_fwd_valA1");
        step();
        drive(1'b0, 4'hF, 64'h0, 4'hF, 64'h0);
        push_reads(64'h55, 64'h55, 64'h55, "conflict");
        push_cnt(16'd3, "conflict");
        step();

        // RNONE writes, then a stalled write to reg1.
        drive(1'b1, 4'hF, 64'h77, 4'hF, 64'h88);
        rd(4'd1, 4'hF, 4'hF);
        step();
        drive(1'b0, 4'd1, 64'h9, 4'hF, 64'h0);
        push(4, 64'h0, "stall_nofwd_valA1");
        step();
        drive(1'b0, 4'hF, 64'h0, 4'hF, 64'h0);
        push_reads(64'h0, 64'h0, 64'h0, "rnone_stall");
        push_cnt(16'd3, "rnone_stall");
        step();

        // Bypass: reg5=3, then E-port write of 0x10 read in the same cycle.
        drive(1'b1, 4'd5, 64'h3, 4'hF, 64'h0);
        step();
        drive(1'b1, 4'd5, 64'h10, 4'hF, 64'h0);
        rd(4'd5, 4'd5, 4'd5);
        push(0, 64'h3, "byp_valA0"); push(4, 64'h10, "byp_valA1");
        push(2, 64'h3, "byp_dbg0");  push(6, 64'h3, "byp_dbg1");
        step();
        drive(1'b0, 4'hF, 64'h0, 4'hF, 64'h0);
        push_reads(64'h10, 64'h10, 64'h10, "byp_after");
        push_cnt(16'd5, "byp_after");
        step();

        // Reset mid-stream: no forwarding while in reset, write lost.
        rst_n = 1'b0;
        drive(1'b1, 4'd5, 64'h77, 4'hF, 64'h0);
        rd(4'd5, 4'd4, 4'd5);
        push(0, 64'h10, "rstmid_valA0"); push(4, 64'h10, "rstmid_valA1");
        step();
        rst_n = 1'b1;
        drive(1'b0, 4'hF, 64'h0, 4'hF, 64'h0);
        push_reads(64'h0, 64'h200, 64'h0, "rstmid_after");
        push_cnt(16'd0, "rstmid_after");
        step();

        // Saturation: 32767 dual writes reach 0xFFFE.
        for (int i = 0; i < 32767; i++) begin
            drive(1'b1, 4'd0, 64'(i), 4'd1, 64'(i + 1));
            step();
        end
        drive(1'b0, 4'hF, 64'h0, 4'hF, 64'h0);
        rd(4'd0, 4'd1, 4'd1);
        push_reads(64'd32766, 64'd32767, 64'd32767, "preload");
        push_cnt(16'hFFFE, "preload");
        step();
        drive(1'b1, 4'd2, 64'hC2, 4'd3, 64'hC3);
        step();
        drive(1'b0, 4'hF, 64'h0, 4'hF, 64'h0);
        rd(4'd2, 4'd3, 4'd3);
        push_reads(64'hC2, 64'hC3, 64'hC3, "sat");
        push_cnt(16'hFFFF, "sat");
        step();
        drive(1'b1, 4'd6, 64'hE6, 4'd8, 64'hE8);
        step();
        drive(1'b0, 4'hF, 64'h0, 4'hF, 64'h0);
        rd(4'd6, 4'd8, 4'd8);
        push_reads(64'hE6, 64'hE8, 64'hE8, "sat_hold");
        push_cnt(16'hFFFF, "sat_hold");
        step();

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Y86-64 architectural register file: the consumer of the dstE/dstM destination IDs produced by the write-back destination select.
- Holds registers 0-14 (%rax..%r14), 64 bits each.
- Two write ports: E takes valE to dstE, M takes valM to dstM. Two read ports (srcA, srcB) serve decode.
- ID 15 (RNONE) is never stored. Optional same-cycle bypass lets the same block serve the later pipelined core.

Parameters:
- DATA_W, 64, register width in bits.
- STACK_INIT, 64'h0, reset value of register 4 (%rsp).
- BYPASS, 0. 0 = reads return pre-edge contents; 1 = reads forward same-cycle write data.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- wr_en  input  1  global write enable; 0 = stall, no writes.
- dstE  input  4  E-port destination ID; 15 = no write.
- valE  input  DATA_W  E-port write data.
- dstM  input  4  M-port destination ID; 15 = no write.
- valM  input  DATA_W  M-port write data.
- srcA  input  4  read port A ID; 15 = none.
- srcB  input  4  read port B ID; 15 = none.
- valA  output  DATA_W  read data A.
- valB  output  DATA_W  read data B.
- dbg_sel  input  4  debug read ID.
- dbg_val  output  DATA_W  debug read data, always pre-edge contents, never bypassed.
- wr_count  output  16  count of committed register writes.

Behaviour:
- Reset: on a rising clk edge with rst_n=0:
  - regs 0-3 and 5-14 become 0; reg 4 becomes STACK_INIT.
  - wr_count becomes 0.
  - All writes in that cycle are discarded.
  - The reset cycle's read outputs follow the rules below from pre-edge contents. From the next cycle, valA/valB/dbg_val read 0, or STACK_INIT for ID 4.
- Reads are combinational, zero latency.
  - Any ID of 15 reads 0 on valA, valB and dbg_val.
- Writes commit at the rising edge when rst_n=1 and wr_en=1.
  - E port: if dstE != 15, reg[dstE] <= valE.
  - M port: if dstM != 15, reg[dstM] <= valM.
  - The new value is visible on reads in the next cycle.
- Write conflict: if dstE == dstM != 15, M wins and reg gets valM. This makes popq %rsp load the popped value.
- Stall: wr_en=0 blocks both ports. Contents and wr_count hold.
- BYPASS=1: when wr_en=1 and rst_n=1, valA/valB forward same-cycle data.
  - srcX == dstM != 15 returns valM.
  - Otherwise srcX == dstE != 15 returns valE.
  - Otherwise reg[srcX].
  - M has priority, matching the write conflict rule.
  - BYPASS=0: reads never forward; they see pre-edge contents.
- wr_count: at each committing edge, adds the number of distinct registers written: 0, 1 or 2, and 1 when dstE == dstM.
  - Saturates at 16'hFFFF; does not wrap.
- No X propagation: every output is defined for every input ID 0-15.
- Reset mid-stream: pending same-cycle writes are lost. The registers take reset values regardless of dstE/dstM.

Test Plan:
- Reset then read: hold rst_n=0 for 1 edge with STACK_INIT=64'h200 and dstE=3, valE=5. Release and read all IDs: reg4=64'h200, all others 0 (reg3 is 0, not 5), wr_count=0.
- Dual write: dstE=2/valE=64'hAA and dstM=7/valM=64'hBB, wr_en=1, one edge. Then srcA=2 gives 64'hAA, srcB=7 gives 64'hBB, wr_count=2.
- Conflict: dstE=4/valE=64'h1F0 and dstM=4/valM=64'h55, one edge. reg4=64'h55, wr_count increments by 1.
- RNONE and stall: dstE=15, dstM=15 for one edge, then dstE=1/valE=9 with wr_en=0 for one edge. No register changes, wr_count unchanged, srcA=15 reads 0.
- Bypass: BYPASS=1, reg5=3, drive dstE=5/valE=64'h10 with srcA=5. valA=64'h10 in the same cycle, dbg_sel=5 reads 3. With BYPASS=0, valA=3 until after the edge.
- Saturation: preload wr_count to 16'hFFFE, perform a dual write. wr_count=16'hFFFF and holds at 16'hFFFF on further writes.
